// File: rtl/load_store_unit.sv
// Sub-word load/store unit: turns byte/half/word requests into word-aligned
// DataMemory cycles, with read-modify-write for sub-word stores.
//
// state | meaning
// IDLE  | ready for a request
// RD    | memory read; word captured into rd_word_q
// WR    | memory write of merged (or full) word
// RESP  | one-cycle response, load data extended here
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [1:0]        reqSize,
  input  logic              reqUnsigned,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqWdata,
  output logic              respValid,
  output logic [DATA_W-1:0] respRdata,
  output logic              respMisaligned,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  output logic              memWriteEnable,
  output logic              memReadEnable,
  input  logic [DATA_W-1:0] memReadData
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                write_q, write_d;
  logic                unsigned_q, unsigned_d;
  logic                misaligned_q, misaligned_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rd_word_q, rd_word_d;

  logic                req_misaligned;
  logic [DATA_W-1:0]   merge_word;
  logic [7:0]          lane_byte;
  logic [15:0]         lane_half;
  logic [DATA_W-1:0]   load_ext;

  always_comb begin
    req_misaligned = 1'b0;
    case (reqSize)
      SZ_BYTE: req_misaligned = 1'b0;
      SZ_HALF: req_misaligned = reqAddr[0];
      SZ_WORD: req_misaligned = (reqAddr[1:0] != 2'b00);
      default: req_misaligned = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    write_d      = write_q;
    unsigned_d   = unsigned_q;
    misaligned_d = misaligned_q;
    wdata_d      = wdata_q;
    rd_word_d    = rd_word_q;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          addr_d       = reqAddr;
          size_d       = reqSize;
          write_d      = reqWrite;
          unsigned_d   = reqUnsigned;
          wdata_d      = reqWdata;
          misaligned_d = req_misaligned;
          if (req_misaligned)
            state_d = RESP;
          else if (reqWrite && (reqSize == SZ_WORD))
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD: begin
        rd_word_d = memReadData;
        state_d   = write_q ? WR : RESP;
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= 2'b00;
      write_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      misaligned_q <= 1'b0;
      wdata_q      <= '0;
      rd_word_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      write_q      <= write_d;
      unsigned_q   <= unsigned_d;
      misaligned_q <= misaligned_d;
      wdata_q      <= wdata_d;
      rd_word_q    <= rd_word_d;
    end
  end

  // Store merge: only the addressed lane(s) of the read word are replaced.
  always_comb begin
    merge_word = rd_word_q;
    case (size_q)
      SZ_BYTE: begin
        case (addr_q[1:0])
          2'd0:    merge_word[7:0]   = wdata_q[7:0];
          2'd1:    merge_word[15:8]  = wdata_q[7:0];
          2'd2:    merge_word[23:16] = wdata_q[7:0];
          default: merge_word[31:24] = wdata_q[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_q[1])
          merge_word[31:16] = wdata_q[15:0];
        else
          merge_word[15:0]  = wdata_q[15:0];
      end
      default: merge_word = wdata_q;
    endcase
  end

  always_comb begin
    lane_byte = rd_word_q[7:0];
    case (addr_q[1:0])
      2'd0:    lane_byte = rd_word_q[7:0];
      2'd1:    lane_byte = rd_word_q[15:8];
      2'd2:    lane_byte = rd_word_q[23:16];
      default: lane_byte = rd_word_q[31:24];
    endcase
    lane_half = addr_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
  end

  always_comb begin
    load_ext = rd_word_q;
    case (size_q)
      SZ_BYTE: load_ext = unsigned_q ? {24'h000000, lane_byte}
                                     : {{24{lane_byte[7]}}, lane_byte};
      SZ_HALF: load_ext = unsigned_q ? {16'h0000, lane_half}
                                     : {{16{lane_half[15]}}, lane_half};
      default: load_ext = rd_word_q;
    endcase
  end

  // Enables decode straight from state so reset drops them asynchronously.
  assign reqReady       = (state_q == IDLE);
  assign memReadEnable  = (state_q == RD);
  assign memWriteEnable = (state_q == WR);
  assign memAddress     = {addr_q[ADDR_W-1:2], 2'b00};
  assign memWriteData   = (state_q == WR) ? merge_word : '0;
  assign respValid      = (state_q == RESP);
  assign respMisaligned = (state_q == RESP) && misaligned_q;
  assign respRdata      = ((state_q == RESP) && !write_q && !misaligned_q) ? load_ext : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small word memory behind it
// and an independent reference model of memory contents.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        respValid;
  logic [31:0] respRdata;
  logic        respMisaligned;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWriteEnable;
  logic        memReadEnable;
  logic [31:0] memReadData;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqAddr(reqAddr),
    .reqWdata(reqWdata), .respValid(respValid), .respRdata(respRdata),
    .respMisaligned(respMisaligned), .memAddress(memAddress),
    .memWriteData(memWriteData), .memWriteEnable(memWriteEnable),
    .memReadEnable(memReadEnable), .memReadData(memReadData)
  );

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        mis;
    int          lat;
    int          acc;
  } exp_t;

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  exp_t        sb [$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          overlap_cnt = 0;
  int          last_rd_cyc = 0;
  int          last_wr_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign memReadData = mem[memAddress[5:2]];
  always @(posedge clk) if (memWriteEnable) mem[memAddress[5:2]] <= memWriteData;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: lane arithmetic via masks and shifts over ref_mem.
  function automatic exp_t model(input logic w, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] word, v, mask;
    int          sh;
    e.tag   = "";
    e.acc   = 0;
    e.rdata = 32'h0;
    e.mis   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    word    = ref_mem[a[5:2]];
    sh      = int'(a[1:0]) * 8;
    mask    = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    if (e.mis) begin
      e.lat = 1;
    end else if (w) begin
      e.lat = (sz == 2'b10) ? 2 : 3;
      mask  = mask << sh;
      ref_mem[a[5:2]] = (word & ~mask) | ((wd << sh) & mask);
    end else begin
      e.lat = 2;
      v = (word >> sh) & mask;
      if (!uns && sz == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
      if (!uns && sz == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
      e.rdata = v;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (memReadEnable && memWriteEnable) overlap_cnt++;
      if (memReadEnable) begin rd_cnt++; last_rd_cyc = cyc; end
      if (memWriteEnable) begin wr_cnt++; last_wr_cyc = cyc; end
      if (respValid) begin
        if (sb.size() == 0) begin
          check_eq("resp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq($sformatf("%s_data", e.tag), respRdata, e.rdata);
          check_eq($sformatf("%s_mis", e.tag), {31'd0, respMisaligned}, {31'd0, e.mis});
          check_eq($sformatf("%s_lat", e.tag), cyc - e.acc, e.lat);
        end
      end
    end
  end

  task automatic send(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input bit hold,
                      input bit abort, output int waited);
    exp_t e;
    waited = 0;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqUnsigned = uns;
    reqAddr = a; reqWdata = wd;
    while (!reqReady && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!reqReady) begin
      check_eq($sformatf("%s_accept_timeout", tag), 32'd0, 32'd1);
      reqValid = 1'b0;
      return;
    end
    if (!abort) begin
      e = model(w, sz, uns, a, wd);
      e.tag = tag;
      e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) reqValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk); #1;
    while (!(reqReady && sb.size() == 0) && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 50) check_eq("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int rd0, wr0;
    for (int i = 0; i < 16; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    rst_n = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00;
    reqUnsigned = 1'b0; reqAddr = 32'h0; reqWdata = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {31'd0, reqReady}, 32'd1);
    check_eq("rst_resp_valid", {31'd0, respValid}, 32'd0);
    check_eq("rst_resp_rdata", respRdata, 32'h0);
    check_eq("rst_resp_mis", {31'd0, respMisaligned}, 32'd0);
    check_eq("rst_mem_addr", memAddress, 32'h0);
    check_eq("rst_mem_wdata", memWriteData, 32'h0);
    check_eq("rst_enables", {30'd0, memReadEnable, memWriteEnable}, 32'd0);
    rst_n = 1'b1;

    send("st_word", 1'b1, 2'b10, 1'b0, 32'h00, 32'h1234_5678, 1'b0, 1'b0, w);
    send("ld_word", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, w);
    wait_idle();

    rd0 = rd_cnt; wr0 = wr_cnt;
    send("st_byte", 1'b1, 2'b00, 1'b0, 32'h02, 32'h0000_00AB, 1'b0, 1'b0, w);
    wait_idle();
    check_eq("st_byte_rd_cycles", rd_cnt - rd0, 32'd1);
    check_eq("st_byte_wr_cycles", wr_cnt - wr0, 32'd1);
    check_eq("st_byte_rd_then_wr", last_wr_cyc - last_rd_cyc, 32'd1);
    send("ld_after_byte", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, w);

    send("st_pattern", 1'b1, 2'b10, 1'b0, 32'h00, 32'h80FF_7F01, 1'b0, 1'b0, w);
    send("lb_s_1", 1'b0, 2'b00, 1'b0, 32'h01, 32'h0, 1'b0, 1'b0, w);
    send("lb_s_2", 1'b0, 2'b00, 1'b0, 32'h02, 32'h0, 1'b0, 1'b0, w);
    send("lh_u_2", 1'b0, 2'b01, 1'b1, 32'h02, 32'h0, 1'b0, 1'b0, w);
    send("lh_s_2", 1'b0, 2'b01, 1'b0, 32'h02, 32'h0, 1'b0, 1'b0, w);
    send("lb_u_3", 1'b0, 2'b00, 1'b1, 32'h03, 32'h0, 1'b0, 1'b0, w);
    send("lb_s_0", 1'b0, 2'b00, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, w);
    send("sh_6", 1'b1, 2'b01, 1'b0, 32'h06, 32'h1234_BEEF, 1'b0, 1'b0, w);
    send("ld_w4", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b0, 1'b0, w);
    send("lh_s_4", 1'b0, 2'b01, 1'b0, 32'h04, 32'h0, 1'b0, 1'b0, w);
    wait_idle();

    rd0 = rd_cnt; wr0 = wr_cnt;
    send("mis_lw_1", 1'b0, 2'b10, 1'b0, 32'h01, 32'h0, 1'b0, 1'b0, w);
    send("mis_sh_3", 1'b1, 2'b01, 1'b0, 32'h03, 32'hDEAD_BEEF, 1'b0, 1'b0, w);
    send("mis_sz3_0", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, w);
    wait_idle();
    check_eq("mis_no_rd", rd_cnt - rd0, 32'd0);
    check_eq("mis_no_wr", wr_cnt - wr0, 32'd0);

    send("b2b_first", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, w);
    send("b2b_second", 1'b0, 2'b00, 1'b1, 32'h03, 32'h0, 1'b0, 1'b0, w);
    check_eq("b2b_busy_cycles", w, 32'd2);
    wait_idle();

    send("rmw_abort", 1'b1, 2'b00, 1'b0, 32'h00, 32'h0000_0055, 1'b0, 1'b1, w);
    check_eq("abort_in_rd", {31'd0, memReadEnable}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_enables_drop", {30'd0, memReadEnable, memWriteEnable}, 32'd0);
    check_eq("abort_ready", {31'd0, reqReady}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort_ready_release", {31'd0, reqReady}, 32'd1);
    send("ld_after_abort", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, w);
    wait_idle();

    check_eq("sb_drained", sb.size(), 32'd0);
    check_eq("en_overlap", overlap_cnt, 32'd0);
    for (int i = 0; i < 4; i++) check_eq($sformatf("mem_%0d", i), mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sub-word load/store unit between the execute stage and `DataMemory`. It accepts one memory request at a time from the pipeline and translates byte, halfword and word accesses into word-aligned `DataMemory` cycles. Sub-word stores use a read-modify-write sequence. Loads return sign- or zero-extended data, and misaligned requests are flagged without touching memory.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, data width; fixed at 32, so lane logic assumes 4 bytes/word

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `reqValid` in 1: request present
- `reqReady` out 1: unit can accept a request
- `reqWrite` in 1: 1 = store, 0 = load
- `reqSize` in 2: 00 byte, 01 half, 10 word, 11 illegal
- `reqUnsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend
- `reqAddr` in ADDR_W: byte address
- `reqWdata` in DATA_W: store data, right-justified
- `respValid` out 1: one-cycle completion pulse
- `respRdata` out DATA_W: extended load data; 0 for stores and misaligned requests
- `respMisaligned` out 1: qualifies `respValid`; request was aborted
- `memAddress` out ADDR_W: to `DataMemory.address`, always word-aligned
- `memWriteData` out DATA_W: to `DataMemory.writeData`
- `memWriteEnable` out 1: to `DataMemory.writeEnable`
- `memReadEnable` out 1: to `DataMemory.readEnable`
- `memReadData` in DATA_W: from `DataMemory.readData`; combinational read, valid in the same cycle as `memReadEnable`

## Operation
- Handshake: a request is accepted on a rising edge where `reqValid && reqReady`. `reqReady = (state == IDLE)`.
- On accept, latch address, size, write, unsigned and wdata. Request inputs are ignored until the unit returns to IDLE.
- Memory address: `{addr[31:2], 2'b00}`. Lane is `addr[1:0]`, little-endian.
- Misaligned: `reqSize == 11`; half with `addr[0] == 1`; word with `addr[1:0] != 0`. Any of these goes IDLE→RESP with `respMisaligned = 1` and no memory enable asserted.
- FSM states: IDLE, RD, WR, RESP.
  - Load: IDLE→RD→RESP→IDLE.
  - Word store: IDLE→WR→RESP→IDLE.
  - Byte/half store: IDLE→RD→WR→RESP→IDLE.
- RD state:
  - `memReadEnable = 1`.
  - `memReadData` is registered into `rdWord` at the end of the cycle.
- WR state:
  - `memWriteEnable = 1`.
  - `memWriteData` is `rdWord` with the addressed lane(s) replaced by `reqWdata[7:0]` or `[15:0]`. Word stores use the full `reqWdata`.
  - `DataMemory` commits on the clock edge ending WR.
- RESP state:
  - `respValid = 1` for exactly one cycle.
  - For loads, `respRdata` holds the extracted lane extended per `reqUnsigned`. Extension is from bit 7 for bytes and bit 15 for halves.
- No response backpressure: the consumer must take `respValid` in the cycle it is high.
- `memReadEnable` and `memWriteEnable` are never high in the same cycle. Both are 0 in IDLE and RESP.

## Timing
- Reset (async, any state) drives:
  - state = IDLE, so `reqReady = 1`
  - `respValid = 0`, `respRdata = 0`, `respMisaligned = 0`
  - `memAddress = 0`, `memWriteData = 0`, `memWriteEnable = 0`, `memReadEnable = 0`
  - `rdWord = 0`
- Reset mid-RMW: if reset asserts during RD or before the WR edge, no write is committed. Enables drop immediately (asynchronously).
- Latency, counted from the accept edge N:
  - load or word store: `respValid` during cycle N+2
  - sub-word store: `respValid` during cycle N+3
  - misaligned: `respValid` during cycle N+1
- Throughput: next accept is possible on the edge ending RESP+1, i.e. while in IDLE.
- Back-to-back requests: `reqValid` held high across a response is accepted in the first IDLE cycle.
- `memAddress` is stable from RD through WR of a single request.

## Test plan
- Reset then word store: reset with `rst_n = 0`, then release. Store word `0x12345678` @ `0x00`, then load word @ `0x00`. Required: `respRdata = 0x12345678`; store `respValid` 2 cycles after accept.
- Byte store RMW: mem[0] = `0x12345678`. Store byte `0xAB` @ `0x02`, then load word @ `0x00`. Required: `0x12AB5678`; the store shows RD then WR, and `respValid` 3 cycles after accept.
- Signed/unsigned loads: mem[0] = `0x80FF7F01`.
  - load byte signed @ `0x01` → `0x0000007F`
  - load byte signed @ `0x02` → `0xFFFFFFFF`
  - load half unsigned @ `0x02` → `0x000080FF`
  - load half signed @ `0x02` → `0xFFFF80FF`
- Misaligned: word load @ `0x01`, half store @ `0x03`, size `11` @ `0x00`. Required for each: `respMisaligned = 1` at accept+1, no memory enable asserted, memory contents unchanged.
- Busy/back-to-back: hold `reqValid` high for two loads. Required: `reqReady = 0` during RD/RESP, second request accepted only in IDLE, both responses correct.
- Reset mid-RMW: assert `rst_n = 0` during RD of a byte store. Required: enables go to 0 immediately, memory unchanged, `reqReady = 1` after release.
